ooo_fetch2_decode_ctrl: RTL and testbench

Sequences instruction handoff from the fetch2 stage to decode in the out-of-order front end. Buffers fetched instructions in a small FIFO, drives the fetch2→decode bundle (pc, pc4, instr, prediction, fault flags, token), and applies ready/valid back-pressure to fetch2. Handles flush and freeze, and fences fetch behind any faulting instruction. Exposes occupancy and a saturating bubble counter for performance monitoring.

---
 rtl/ooo_fetch2_decode_ctrl_if.sv | 29 ++
 rtl/ooo_fetch2_decode_ctrl.sv | 84 ++++++++
 tb/tb_ooo_fetch2_decode_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ooo_fetch2_decode_ctrl_if.sv
// ooo_fetch2_decode_ctrl_if: fetch2->decode handshake and payload bundle
// master: drives the fetch2 offer and the decode ready and observes the presented bundle.
// slave: the controller side; accepts the fetch2 offer and presents the head entry to decode.
interface ooo_fetch2_decode_ctrl_if;
    logic        f2_valid;
    logic [31:0] f2_pc;
    logic [31:0] f2_pc4;
    logic [31:0] f2_instr;
    logic        f2_prediction;
    logic        f2_mal_insn;
    logic        f2_fault_insn;
    logic        f2_ready;
    logic        dec_ready;
    logic        token;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        prediction;
    logic        mal_insn;
    logic        fault_insn;
    modport master (
        output f2_valid, f2_pc, f2_pc4, f2_instr, f2_prediction, f2_mal_insn, f2_fault_insn, dec_ready,
        input  f2_ready, token, pc, pc4, instr, prediction, mal_insn, fault_insn
    );
    modport slave (
        input  f2_valid, f2_pc, f2_pc4, f2_instr, f2_prediction, f2_mal_insn, f2_fault_insn, dec_ready,
        output f2_ready, token, pc, pc4, instr, prediction, mal_insn, fault_insn
    );
endinterface

// File: rtl/ooo_fetch2_decode_ctrl.sv
// ooo_fetch2_decode_ctrl: fetch2->decode instruction FIFO with fault fence, flush/freeze and bubble counter
// Ports: clk_i, rst_i (sync, active-high); flush_i drops all buffered and incoming entries;
// freeze_i holds all state; bus (slave) carries the fetch2 offer and decode bundle;
// occupancy_o is the entry count; bubble_count_o saturates counting cycles with no token.
module ooo_fetch2_decode_ctrl #(
    parameter int DEPTH  = 2,
    parameter int PERF_W = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      freeze_i,
    ooo_fetch2_decode_ctrl_if.slave   bus,
    output logic [$clog2(DEPTH):0]    occupancy_o,
    output logic [PERF_W-1:0]         bubble_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] FENCED = 1'b1;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        prediction;
        logic        mal_insn;
        logic        fault_insn;
    } ent_t;
    ent_t          mem_q [DEPTH];
    ent_t          head;
    ent_t          wdata;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [AW:0]   cnt_q;
    logic [0:0]    st_q;
    logic [PERF_W-1:0] bub_q;
    logic          enq;
    logic          deq;
    assign head  = mem_q[rd_q];
    assign wdata = '{bus.f2_pc, bus.f2_pc4, bus.f2_instr, bus.f2_prediction, bus.f2_mal_insn, bus.f2_fault_insn};
    // Back-pressure depends only on registered state plus flush/freeze, never on dec_ready.
    assign bus.f2_ready = (cnt_q < FULL) & ~flush_i & ~freeze_i & ~rst_i & (st_q == RUN);
    assign bus.token    = (cnt_q != '0) & ~flush_i & ~rst_i;
    assign bus.pc         = head.pc;
    assign bus.pc4        = head.pc4;
    assign bus.instr      = head.instr;
    assign bus.prediction = head.prediction;
    assign bus.mal_insn   = head.mal_insn;
    assign bus.fault_insn = head.fault_insn;
    assign enq = bus.f2_valid & bus.f2_ready;
    assign deq = bus.token & bus.dec_ready & ~freeze_i;
    assign occupancy_o    = cnt_q;
    assign bubble_count_o = bub_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            st_q  <= RUN;
            bub_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (!freeze_i && !bus.token && bub_q != '1) bub_q <= bub_q + 1'b1;
            if (flush_i) begin
                rd_q  <= '0;
                wr_q  <= '0;
                cnt_q <= '0;
                st_q  <= RUN;
            end else if (!freeze_i) begin
                if (enq) begin
                    mem_q[wr_q] <= wdata;
                    wr_q        <= wr_q + 1'b1;
                end
                if (deq) rd_q <= rd_q + 1'b1;
                cnt_q <= cnt_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
                // Fetch stops once a fault enqueues, so the faulting entry is the youngest:
                // it leaves exactly when the dequeue empties the buffer.
                if (enq && (wdata.mal_insn || wdata.fault_insn)) st_q <= FENCED;
                else if (deq && cnt_q == ONE) st_q <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_ooo_fetch2_decode_ctrl.sv
// tb_ooo_fetch2_decode_ctrl: directed and randomized checks against a queue-based model
module tb_ooo_fetch2_decode_ctrl;
    localparam int DEPTH = 2;
    localparam int PERF_W = 4;
    localparam int BMAX = (1 << PERF_W) - 1;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        pred;
        logic        mal;
        logic        fault;
    } ent_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic freeze = 1'b0;
    logic [$clog2(DEPTH):0] occ;
    logic [PERF_W-1:0] bub;
    ooo_fetch2_decode_ctrl_if bus();
    ooo_fetch2_decode_ctrl #(.DEPTH(DEPTH), .PERF_W(PERF_W)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .freeze_i(freeze),
        .bus(bus), .occupancy_o(occ), .bubble_count_o(bub)
    );
    always #5 clk = ~clk;
    int tests = 0;
    int fails = 0;
    ent_t q[$];
    logic [31:0] cons[$];
    bit fenced = 0;
    int bubble = 0;
    bit fresh = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic ent_t mk(input logic [31:0] pc, input bit mal, input bit fault);
        ent_t e;
        e.pc = pc;
        e.pc4 = pc + 32'd4;
        e.instr = $urandom;
        e.pred = 1'($urandom_range(0, 1));
        e.mal = mal;
        e.fault = fault;
        return e;
    endfunction
    task automatic cycle(input bit r, input bit fl, input bit fz, input bit v, input bit dr, input ent_t e);
        bit et, er, deq, enq;
        ent_t h;
        @(negedge clk);
        rst = r; flush = fl; freeze = fz;
        bus.f2_valid = v; bus.dec_ready = dr;
        bus.f2_pc = e.pc; bus.f2_pc4 = e.pc4; bus.f2_instr = e.instr;
        bus.f2_prediction = e.pred; bus.f2_mal_insn = e.mal; bus.f2_fault_insn = e.fault;
        #1;
        et = !r && q.size() > 0 && !fl;
        er = !r && q.size() < DEPTH && !fl && !fz && !fenced;
        chk("token", 32'(bus.token), 32'(et));
        chk("f2_ready", 32'(bus.f2_ready), 32'(er));
        chk("occupancy", 32'(occ), 32'(q.size()));
        chk("bubble_count", 32'(bub), 32'(bubble));
        if (et) begin
            h = q[0];
            chk("pc", bus.pc, h.pc);
            chk("pc4", bus.pc4, h.pc4);
            chk("instr", bus.instr, h.instr);
            chk("flags", {29'd0, bus.prediction, bus.mal_insn, bus.fault_insn}, {29'd0, h.pred, h.mal, h.fault});
        end else if (fresh && !r) begin
            chk("zero_payload", bus.pc | bus.pc4 | bus.instr, 32'd0);
            chk("zero_flags", {29'd0, bus.prediction, bus.mal_insn, bus.fault_insn}, 32'd0);
        end
        if (r) begin
            q.delete(); fenced = 0; bubble = 0; fresh = 1;
        end else begin
            if (!fz && !et && bubble < BMAX) bubble++;
            if (fl) begin
                q.delete(); fenced = 0;
            end else if (!fz) begin
                deq = et && dr;
                enq = v && er;
                if (deq) begin
                    h = q.pop_front();
                    cons.push_back(h.pc);
                    if (h.mal || h.fault) fenced = 0;
                end
                if (enq) begin
                    q.push_back(e);
                    fresh = 0;
                    if (e.mal || e.fault) fenced = 1;
                end
            end
        end
    endtask
    task automatic idle(input bit dr);
        cycle(0, 0, 0, 0, dr, '0);
    endtask
    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, '0);
        cycle(1, 0, 0, 0, 0, '0);
    endtask
    initial begin
        bus.f2_valid = 0; bus.dec_ready = 0;
        bus.f2_pc = '0; bus.f2_pc4 = '0; bus.f2_instr = '0;
        bus.f2_prediction = 0; bus.f2_mal_insn = 0; bus.f2_fault_insn = 0;
        do_reset();
        // Streaming: 8 instructions with decode always ready.
        cons.delete();
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 1, 1, mk(32'h100 + 32'(4 * i), 0, 0));
            if (i == 0) begin
                chk("lit_first_ready", 32'(bus.f2_ready), 32'd1);
                chk("lit_first_token", 32'(bus.token), 32'd0);
            end
            if (i == 1) chk("lit_first_pc", bus.pc, 32'h100);
            if (i >= 1) chk("lit_stream_occ", 32'(occ), 32'd1);
        end
        idle(1);
        chk("lit_stream_bubble", 32'(bub), 32'd1);
        idle(1);
        chk("lit_stream_count", 32'(cons.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("lit_stream_order", cons[i], 32'h100 + 32'(4 * i));
        // Back-pressure fill/drain over 5 rounds.
        cons.delete();
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0, mk(32'h1000 + 32'(16 * r + 4 * k), 0, 0));
            chk("lit_full_occ", 32'(occ), 32'd2);
            chk("lit_full_ready", 32'(bus.f2_ready), 32'd0);
            idle(1); idle(1); idle(1);
        end
        chk("lit_bp_count", 32'(cons.size()), 32'd10);
        for (int i = 0; i < 10; i++) chk("lit_bp_order", cons[i], 32'h1000 + 32'(16 * (i / 2) + 4 * (i % 2)));
        // Flush with 2 entries buffered and a new offer in the same cycle.
        cycle(0, 0, 0, 1, 0, mk(32'h300, 0, 0));
        cycle(0, 0, 0, 1, 0, mk(32'h304, 0, 0));
        cycle(0, 1, 0, 1, 0, mk(32'h308, 0, 0));
        chk("lit_flush_token", 32'(bus.token), 32'd0);
        idle(0);
        chk("lit_flush_occ", 32'(occ), 32'd0);
        chk("lit_flush_ready", 32'(bus.f2_ready), 32'd1);
        // Fault fence released by dequeue, then by flush.
        cycle(0, 0, 0, 1, 0, mk(32'h200, 0, 1));
        cycle(0, 0, 0, 1, 0, mk(32'h204, 0, 0));
        chk("lit_fence_ready", 32'(bus.f2_ready), 32'd0);
        chk("lit_fence_pc", bus.pc, 32'h200);
        idle(1);
        idle(0);
        chk("lit_unfence_ready", 32'(bus.f2_ready), 32'd1);
        cycle(0, 0, 0, 1, 0, mk(32'h210, 1, 0));
        idle(0);
        chk("lit_fence2_ready", 32'(bus.f2_ready), 32'd0);
        cycle(0, 1, 0, 0, 0, '0);
        idle(0);
        chk("lit_flush_unfence", 32'(bus.f2_ready), 32'd1);
        // Freeze with one entry buffered and decode ready.
        cycle(0, 0, 0, 1, 0, mk(32'h400, 0, 0));
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 1, 1, 1, mk(32'h404, 0, 0));
            chk("lit_freeze_occ", 32'(occ), 32'd1);
            chk("lit_freeze_pc", bus.pc, 32'h400);
        end
        idle(1);
        idle(0);
        chk("lit_unfreeze_occ", 32'(occ), 32'd0);
        // Reset mid-operation, then saturation.
        cycle(0, 0, 0, 1, 0, mk(32'h500, 0, 0));
        cycle(0, 0, 0, 1, 0, mk(32'h504, 0, 0));
        cycle(1, 0, 0, 1, 1, mk(32'h508, 0, 0));
        idle(0);
        chk("lit_rst_occ", 32'(occ), 32'd0);
        chk("lit_rst_bubble", 32'(bub), 32'd0);
        chk("lit_rst_pc", bus.pc, 32'd0);
        for (int k = 0; k < 20; k++) idle(0);
        chk("lit_saturate", 32'(bub), 32'd15);
        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  mk($urandom, $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
